// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Program counter and instruction-fetch sequencer. Picks the next PC from the
// decoder's branch/jump controls and drives the instruction memory address
// combinationally, so a redirect costs no bubble. The PC is held while a
// data-memory access is in progress and while scan shifting is active.
// Optional feature macro: PC_PERF_CNT_EN adds o_stall_cycles, a saturating
// count of stalled cycles that is frozen during scan.
// Handshake: there is no valid/ready pair. o_stall high means the IR and the
// RF write port must hold this cycle; o_imem_ceb low means o_imem_addr is read.
module pc_fetch_sequencer #(
    parameter int PC_W = 16,
    parameter int DISP_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_global_reset,
    input  logic              i_scan_en,
    input  logic              i_bcond,
    input  logic              i_jcond,
    input  logic              i_jal,
    input  logic [DISP_W-1:0] i_disp,
    input  logic [PC_W-1:0]   i_jump_target,
    input  logic              i_dmem_ceb,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic              o_imem_ceb,
    output logic [PC_W-1:0]   o_link_addr,
    output logic              o_stall,
`ifdef PC_PERF_CNT_EN
    output logic [15:0]       o_stall_cycles,
`endif
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_MEMW = 2'd2,
        ST_SCAN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_npc;
    logic [3:0]      r_wait_cnt;
    logic [3:0]      w_next_wait;
    logic [PC_W-1:0] w_disp_ext;
    logic [PC_W-1:0] w_pc_inc;

    assign w_disp_ext  = {{(PC_W-DISP_W){i_disp[DISP_W-1]}}, i_disp};
    assign w_pc_inc    = r_pc + 1'b1;
    assign o_pc        = r_pc;
    assign o_link_addr = w_pc_inc;
    assign o_dbg_state = r_state;

    // State, PC and wait counter; reset abandons any pending access at once.
    always_ff @(posedge i_clk or posedge i_global_reset) begin
        if (i_global_reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_npc;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Next-state, next-PC and fetch outputs; default is "hold and stall".
    always_comb begin
        w_next_state = r_state;
        w_npc        = r_pc;
        w_next_wait  = r_wait_cnt;
        o_imem_addr  = r_pc;
        o_imem_ceb   = 1'b0;
        o_stall      = 1'b1;
        case (r_state)
            ST_BOOT: begin
                w_next_state = i_scan_en ? ST_SCAN : ST_RUN;
            end
            ST_RUN: begin
                o_stall = 1'b0;
                if (i_scan_en) begin
                    o_stall      = 1'b1;
                    w_next_state = ST_SCAN;
                end else if (!i_dmem_ceb) begin
                    // Memory access beats any branch issued in the same cycle.
                    o_stall      = 1'b1;
                    w_next_state = ST_MEMW;
                    w_next_wait  = 4'(MEM_LAT);
                end else if (i_jal || i_jcond) begin
                    w_npc = i_jump_target;
                end else if (i_bcond) begin
                    w_npc = r_pc + w_disp_ext;
                end else begin
                    w_npc = w_pc_inc;
                end
                o_imem_addr = w_npc;
            end
            ST_MEMW: begin
                // dmem_ceb is not looked at here, so an access cannot retrigger.
                w_next_wait = r_wait_cnt - 4'd1;
                if (r_wait_cnt == 4'd1) begin
                    w_npc        = w_pc_inc;
                    o_imem_addr  = w_pc_inc;
                    w_next_state = ST_RUN;
                end
            end
            ST_SCAN: begin
                o_imem_ceb = 1'b1;
                if (!i_scan_en) begin
                    w_next_state = ST_BOOT;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

`ifdef PC_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    assign o_stall_cycles = r_stall_cycles;

    // Saturating stall counter, frozen while scan is shifting.
    always_ff @(posedge i_clk or posedge i_global_reset) begin
        if (i_global_reset) begin
            r_stall_cycles <= '0;
        end else if (o_stall && (r_state != ST_SCAN) && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
// Directed scenarios followed by randomized stimulus. A reference model
// tracks the sequencer as "pending bubbles" (boot, memory wait, scan) and
// pushes the expected outputs of every cycle; a monitor compares them.
module tb_pc_fetch_sequencer;

    localparam int MEM_LAT = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] link;
        logic        ceb;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_en = 1'b0;
    logic        bcond = 1'b0;
    logic        jcond = 1'b0;
    logic        jal = 1'b0;
    logic [7:0]  disp = 8'h00;
    logic [15:0] jump_target = 16'h0000;
    logic        dmem_ceb = 1'b1;
    logic [15:0] pc, imem_addr, link_addr;
    logic        imem_ceb, stall;
    logic [1:0]  dbg_state;
`ifdef PC_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model state.
    logic [15:0] m_pc = RESET_PC;
    bit          m_boot = 1'b1;
    bit          m_scan = 1'b0;
    int          m_mem_left = 0;
    int          m_cnt = 0;

    pc_fetch_sequencer #(
        .PC_W(16), .DISP_W(8), .RESET_PC(RESET_PC), .MEM_LAT(MEM_LAT)
    ) dut (
        .i_clk(clk),
        .i_global_reset(rst),
        .i_scan_en(scan_en),
        .i_bcond(bcond),
        .i_jcond(jcond),
        .i_jal(jal),
        .i_disp(disp),
        .i_jump_target(jump_target),
        .i_dmem_ceb(dmem_ceb),
        .o_pc(pc),
        .o_imem_addr(imem_addr),
        .o_imem_ceb(imem_ceb),
        .o_link_addr(link_addr),
        .o_stall(stall),
`ifdef PC_PERF_CNT_EN
        .o_stall_cycles(stall_cycles),
`endif
        .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc = RESET_PC;
        m_boot = 1'b1;
        m_scan = 1'b0;
        m_mem_left = 0;
        m_cnt = 0;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict, push.
    task automatic cycle(input logic r, input logic s, input logic b, input logic jc,
                         input logic jl, input logic [7:0] d, input logic [15:0] tgt,
                         input logic ceb);
        exp_t e;
        logic [15:0] npc;
        bit in_scan;
        @(negedge clk);
        rst = r; scan_en = s; bcond = b; jcond = jc; jal = jl;
        disp = d; jump_target = tgt; dmem_ceb = ceb;
        if (r) model_reset();
        e.pc = m_pc;
        e.link = m_pc + 16'd1;
        e.ceb = 1'b0;
        e.stall = 1'b1;
        e.cnt = 16'(m_cnt);
        e.addr = m_pc;
        npc = m_pc;
        in_scan = m_scan;
        if (r) begin
            // held in reset: outputs are the boot values, nothing advances
        end else if (m_scan) begin
            e.ceb = 1'b1;
            if (!s) begin m_scan = 1'b0; m_boot = 1'b1; end
        end else if (m_mem_left > 0) begin
            if (m_mem_left == 1) npc = m_pc + 16'd1;
            e.addr = npc;
            m_mem_left--;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (s) m_scan = 1'b1;
        end else begin
            e.stall = 1'b0;
            if (s) begin
                e.stall = 1'b1;
                m_scan = 1'b1;
            end else if (!ceb) begin
                e.stall = 1'b1;
                m_mem_left = MEM_LAT;
            end else if (jl || jc) begin
                npc = tgt;
            end else if (b) begin
                npc = 16'(int'(m_pc) + int'($signed(d)));
            end else begin
                npc = m_pc + 16'd1;
            end
            e.addr = npc;
        end
        exp_q.push_back(e);
        if (!r) begin
            m_pc = npc;
            if (e.stall && !in_scan && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 8'h00, 16'h0, 1);
    endtask

    task automatic jump_to(input logic [15:0] tgt);
        cycle(0, 0, 0, 0, 1, 8'h00, tgt, 1);
    endtask

    // Monitor: pops one expectation per cycle, after inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", 32'(pc), 32'(e.pc));
                check("imem_addr", 32'(imem_addr), 32'(e.addr));
                check("link_addr", 32'(link_addr), 32'(e.link));
                check("imem_ceb", 32'(imem_ceb), 32'(e.ceb));
                check("stall", 32'(stall), 32'(e.stall));
`ifdef PC_PERF_CNT_EN
                check("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
`endif
            end
        end
    end

    // Driver
    initial begin
        logic r, s, b, jc, jl, ceb;
        // Reset state, then release: BOOT one cycle, then sequential fetch.
        cycle(1, 0, 0, 0, 0, 8'h00, 16'h0, 1);
        cycle(1, 0, 0, 0, 0, 8'h00, 16'h0, 1);
        idle(5);
        // Backward branch from 0x0010 by -4.
        jump_to(16'h0010);
        cycle(0, 0, 1, 0, 0, 8'hFC, 16'h0, 1);
        idle(1);
        // JAL from 0x0020, alone and together with a branch.
        jump_to(16'h0020);
        cycle(0, 0, 0, 0, 1, 8'h00, 16'h1234, 1);
        jump_to(16'h0020);
        cycle(0, 0, 1, 0, 1, 8'h05, 16'h1234, 1);
        cycle(0, 0, 1, 1, 0, 8'h05, 16'h0777, 1);
        // Memory access at 0x0040, with a branch that must be ignored.
        jump_to(16'h0040);
        cycle(0, 0, 1, 0, 0, 8'h10, 16'h0, 0);
        cycle(0, 0, 0, 0, 0, 8'h00, 16'h0, 0);
        idle(3);
        // Wraparound cases.
        jump_to(16'hFFFF);
        idle(2);
        jump_to(16'h0002);
        cycle(0, 0, 1, 0, 0, 8'h80, 16'h0, 1);
        idle(1);
        // Asynchronous reset in the middle of a memory wait.
        jump_to(16'h0050);
        cycle(0, 0, 0, 0, 0, 8'h00, 16'h0, 0);
        cycle(0, 0, 0, 0, 0, 8'h00, 16'h0, 1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(pc), 32'(RESET_PC));
        check("async_rst_stall", 32'(stall), 32'd1);
        check("async_rst_addr", 32'(imem_addr), 32'(RESET_PC));
        model_reset();
        cycle(1, 0, 0, 0, 0, 8'h00, 16'h0, 1);
        idle(3);
        // Scan for five cycles, then BOOT refetches the frozen pc.
        jump_to(16'h0300);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 8'h00, 16'h0, 1);
        idle(4);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 99) < 6);
            b   = ($urandom_range(0, 3) == 0);
            jc  = ($urandom_range(0, 7) == 0);
            jl  = ($urandom_range(0, 7) == 0);
            ceb = ($urandom_range(0, 9) != 0);
            cycle(r, s, b, jc, jl, 8'($urandom_range(0, 255)), 16'($urandom), ceb);
        end
        idle(2);
        repeat (3) @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
